timer_event_ctrl: RTL

Downstream consumer of the 16-bit timer's done/done_ack handshake. Detects each timer expiry and acknowledges it back to the timer. Keeps a running event count and coalesces expiries into a CPU-facing interrupt, raised after a programmable number of events. Sits between the timer and the CPUy interrupt/register logic.

---
 rtl/timer_event_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/timer_event_ctrl.sv
// Timer done/done_ack consumer: counts expiries, acknowledges them and coalesces them into an irq.
// Optional TIMER_EVT_OVERRUN_EN adds an overrun flag for threshold crossings while irq is pending.
module timer_event_ctrl #(
  parameter int unsigned CW          = 8,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          done,
  output logic          done_ack,
  input  logic          irq_en,
  input  logic [CW-1:0] irq_threshold,
  input  logic          irq_ack,
  input  logic          clr_count,
  output logic [CW-1:0] event_count,
  output logic          irq,
  output logic          busy,
  output logic          fault
`ifdef TIMER_EVT_OVERRUN_EN
  ,
  output logic          overrun
`endif
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACK, HOLDOFF, FAULT} state_t;

  state_t        state, next_state;
  logic [TW-1:0] tmo_cnt, tmo_d;
  logic          done_ack_d, busy_d, fault_d, evt;

  logic [CW-1:0] coal_cnt, coal_d, thr_eff;
  logic [CW:0]   coal_sum;
  logic          thr_hit, irq_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tmo_cnt  <= '0;
      done_ack <= 1'b0;
      busy     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= next_state;
      tmo_cnt  <= tmo_d;
      done_ack <= done_ack_d;
      busy     <= busy_d;
      fault    <= fault_d;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (done) next_state = ACK;
      ACK: begin
        if (!done)                   next_state = HOLDOFF;
        else if (tmo_cnt == TMO_LAST) next_state = FAULT;
      end
      HOLDOFF: next_state = IDLE;
      FAULT:   if (clr_count) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs are decoded from next_state so they change on the same edge as the state.
  always_comb begin
    evt        = (state == IDLE) && done;
    done_ack_d = (next_state == ACK);
    busy_d     = (next_state != IDLE);
    fault_d    = (next_state == FAULT);
    tmo_d      = ((state == ACK) && (next_state == ACK)) ? tmo_cnt + 1'b1 : '0;
  end

  // A threshold lowered below the pending count is simply a hit on the next edge.
  always_comb begin
    thr_eff  = (irq_threshold == '0) ? CW'(1) : irq_threshold;
    coal_sum = {1'b0, coal_cnt} + {{CW{1'b0}}, evt};
    thr_hit  = (coal_sum >= {1'b0, thr_eff});
    irq_set  = thr_hit && irq_en;
    if (!thr_hit)    coal_d = coal_sum[CW-1:0];
    else if (irq_en) coal_d = '0;
    else             coal_d = thr_eff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_count <= '0;
      coal_cnt    <= '0;
      irq         <= 1'b0;
    end else begin
      if (clr_count) event_count <= '0;
      else if (evt)  event_count <= event_count + 1'b1;
      coal_cnt <= coal_d;
      irq      <= irq_set | (irq & ~irq_ack);
    end
  end

`ifdef TIMER_EVT_OVERRUN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun <= 1'b0;
    else     overrun <= (irq_set & irq) | (overrun & ~irq_ack);
  end
`endif

endmodule
